// File: rtl/control_entrada_suma_pkg.sv
// Shared types, key codes and helpers for the keypad sequencer of the 3-digit BCD adder.
package pkg_teclado;

  localparam logic [3:0] TECLA_MAS    = 4'hA;
  localparam logic [3:0] TECLA_IGUAL  = 4'hB;
  localparam logic [3:0] TECLA_BORRAR = 4'hC;

  typedef enum logic [1:0] {
    BARRIDO = 2'd0,
    REBOTE  = 2'd1,
    SOLTAR  = 2'd2
  } escaner_e;

  typedef enum logic [1:0] {
    ENTRADA_A = 2'd0,
    ENTRADA_B = 2'd1,
    RESULTADO = 2'd2
  } control_e;

  localparam logic [1:0] MOSTRAR_A    = 2'd0;
  localparam logic [1:0] MOSTRAR_B    = 2'd1;
  localparam logic [1:0] MOSTRAR_SUMA = 2'd2;

  // Row-major keypad layout; column index is the bit position on columnas.
  function automatic logic [3:0] decodifica(input logic [1:0] fila, input logic [1:0] col);
    logic [3:0] codigo;
    case ({fila, col})
      4'd0:    codigo = 4'h1;
      4'd1:    codigo = 4'h2;
      4'd2:    codigo = 4'h3;
      4'd3:    codigo = 4'hA;
      4'd4:    codigo = 4'h4;
      4'd5:    codigo = 4'h5;
      4'd6:    codigo = 4'h6;
      4'd7:    codigo = 4'hB;
      4'd8:    codigo = 4'h7;
      4'd9:    codigo = 4'h8;
      4'd10:   codigo = 4'h9;
      4'd11:   codigo = 4'hC;
      4'd12:   codigo = 4'hE;
      4'd13:   codigo = 4'h0;
      4'd14:   codigo = 4'hF;
      4'd15:   codigo = 4'hD;
      default: codigo = 4'h0;
    endcase
    return codigo;
  endfunction

  function automatic logic es_digito(input logic [3:0] codigo);
    return (codigo <= 4'd9);
  endfunction

  function automatic logic [1:0] mostrar_de(input control_e estado);
    logic [1:0] m;
    case (estado)
      ENTRADA_A: m = MOSTRAR_A;
      ENTRADA_B: m = MOSTRAR_B;
      RESULTADO: m = MOSTRAR_SUMA;
      default:   m = MOSTRAR_A;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/control_entrada_suma_if.sv
// Operand/display bus from the keypad sequencer towards the BCD adder and display mux.
interface control_entrada_suma_if;
  logic [3:0] dig1_1;
  logic [3:0] dig1_2;
  logic [3:0] dig1_3;
  logic [3:0] dig2_1;
  logic [3:0] dig2_2;
  logic [3:0] dig2_3;
  logic [1:0] mostrar;
  logic       tecla_valida;
  logic [3:0] tecla_codigo;

  modport master (
    output dig1_1, dig1_2, dig1_3, dig2_1, dig2_2, dig2_3,
    output mostrar, tecla_valida, tecla_codigo
  );

  modport slave (
    input dig1_1, dig1_2, dig1_3, dig2_1, dig2_2, dig2_3,
    input mostrar, tecla_valida, tecla_codigo
  );
endinterface

// File: rtl/control_entrada_suma_escaner.sv
// Keypad scanner: column synchroniser, row scan, press/release debounce and key decode.
module teclado_escaner
  import pkg_teclado::*;
#(
  parameter int SCAN_TICKS     = 27000,
  parameter int DEBOUNCE_TICKS = 270000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] columnas_i,
  output logic [3:0] filas_o,
  output logic       tecla_valida_o,
  output logic [3:0] tecla_codigo_o
);

  localparam int MAX_TICKS = (SCAN_TICKS > DEBOUNCE_TICKS) ? SCAN_TICKS : DEBOUNCE_TICKS;
  localparam int CW = $clog2(MAX_TICKS + 1);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_TICKS - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_TICKS - 1);

  logic [3:0]    col_meta_q, col_sync_q;
  escaner_e      estado_q, estado_d;
  logic [1:0]    fila_q, fila_d, col_q, col_d;
  logic [3:0]    filas_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valida_q, valida_d;
  logic [3:0]    codigo_q, codigo_d;
  logic          una_baja_s;
  logic [1:0]    col_baja_s;

  // Exactly one low column is a candidate key; anything else is noise or a chord.
  always_comb begin
    una_baja_s = 1'b1;
    col_baja_s = 2'd0;
    case (col_sync_q)
      4'b1110: col_baja_s = 2'd0;
      4'b1101: col_baja_s = 2'd1;
      4'b1011: col_baja_s = 2'd2;
      4'b0111: col_baja_s = 2'd3;
      default: una_baja_s = 1'b0;
    endcase
  end

  // Scan FSM next-state, counters and key event.
  always_comb begin
    estado_d = estado_q;
    fila_d   = fila_q;
    col_d    = col_q;
    cnt_d    = cnt_q;
    valida_d = 1'b0;
    codigo_d = codigo_q;
    case (estado_q)
      BARRIDO: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = {CW{1'b0}};
          if (una_baja_s) begin
            estado_d = REBOTE;
            col_d    = col_baja_s;
          end else begin
            fila_d = fila_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      REBOTE: begin
        if (una_baja_s && (col_baja_s == col_q)) begin
          if (cnt_q == DEB_LAST) begin
            estado_d = SOLTAR;
            cnt_d    = {CW{1'b0}};
            valida_d = 1'b1;
            codigo_d = decodifica(fila_q, col_q);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          estado_d = BARRIDO;
          cnt_d    = {CW{1'b0}};
        end
      end
      SOLTAR: begin
        if (col_sync_q == 4'hF) begin
          if (cnt_q == DEB_LAST) begin
            estado_d = BARRIDO;
            fila_d   = fila_q + 2'd1;
            cnt_d    = {CW{1'b0}};
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = {CW{1'b0}};
        end
      end
      default: begin
        estado_d = BARRIDO;
        cnt_d    = {CW{1'b0}};
      end
    endcase
  end

  // State, synchroniser and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta_q <= 4'hF;
      col_sync_q <= 4'hF;
      estado_q   <= BARRIDO;
      fila_q     <= 2'd0;
      col_q      <= 2'd0;
      filas_q    <= 4'b1110;
      cnt_q      <= {CW{1'b0}};
      valida_q   <= 1'b0;
      codigo_q   <= 4'h0;
    end else begin
      col_meta_q <= columnas_i;
      col_sync_q <= col_meta_q;
      estado_q   <= estado_d;
      fila_q     <= fila_d;
      col_q      <= col_d;
      filas_q    <= ~(4'b0001 << fila_d);
      cnt_q      <= cnt_d;
      valida_q   <= valida_d;
      codigo_q   <= codigo_d;
    end
  end

  assign filas_o        = filas_q;
  assign tecla_valida_o = valida_q;
  assign tecla_codigo_o = codigo_q;

endmodule

// File: rtl/control_entrada_suma.sv
// Operand entry sequencer: keypad scanner plus control FSM that loads the BCD operands.
module control_entrada_suma
  import pkg_teclado::*;
#(
  parameter int SCAN_TICKS     = 27000,
  parameter int DEBOUNCE_TICKS = 270000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3:0]             columnas,
  output logic [3:0]             filas,
  control_entrada_suma_if.master bus
);

  logic            valida_s;
  logic [3:0]      codigo_s;
  control_e        estado_q, estado_d;
  logic [2:0][3:0] a_q, a_d, b_q, b_d;
  logic [1:0]      na_q, na_d, nb_q, nb_d;
  logic [1:0]      mostrar_q;

  teclado_escaner #(
    .SCAN_TICKS     (SCAN_TICKS),
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
  ) u_escaner (
    .clk            (clk),
    .rst_n          (rst_n),
    .columnas_i     (columnas),
    .filas_o        (filas),
    .tecla_valida_o (valida_s),
    .tecla_codigo_o (codigo_s)
  );

  // Control FSM: index 0 holds units; a full operand ignores further digits.
  always_comb begin
    estado_d = estado_q;
    a_d      = a_q;
    na_d     = na_q;
    b_d      = b_q;
    nb_d     = nb_q;
    if (valida_s) begin
      if (codigo_s == TECLA_BORRAR) begin
        estado_d = ENTRADA_A;
        a_d      = 12'h000;
        na_d     = 2'd0;
        b_d      = 12'h000;
        nb_d     = 2'd0;
      end else begin
        case (estado_q)
          ENTRADA_A: begin
            if (es_digito(codigo_s) && (na_q != 2'd3)) begin
              a_d  = {a_q[1:0], codigo_s};
              na_d = na_q + 2'd1;
            end else if (codigo_s == TECLA_MAS) begin
              estado_d = ENTRADA_B;
              b_d      = 12'h000;
              nb_d     = 2'd0;
            end else begin
              estado_d = estado_q;
            end
          end
          ENTRADA_B: begin
            if (es_digito(codigo_s) && (nb_q != 2'd3)) begin
              b_d  = {b_q[1:0], codigo_s};
              nb_d = nb_q + 2'd1;
            end else if (codigo_s == TECLA_IGUAL) begin
              estado_d = RESULTADO;
            end else begin
              estado_d = estado_q;
            end
          end
          RESULTADO: begin
            if (es_digito(codigo_s)) begin
              estado_d = ENTRADA_A;
              a_d      = {8'h00, codigo_s};
              na_d     = 2'd1;
              b_d      = 12'h000;
              nb_d     = 2'd0;
            end else begin
              estado_d = estado_q;
            end
          end
          default: estado_d = ENTRADA_A;
        endcase
      end
    end else begin
      estado_d = estado_q;
    end
  end

  // Control state, operand registers and display select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q  <= ENTRADA_A;
      a_q       <= 12'h000;
      na_q      <= 2'd0;
      b_q       <= 12'h000;
      nb_q      <= 2'd0;
      mostrar_q <= MOSTRAR_A;
    end else begin
      estado_q  <= estado_d;
      a_q       <= a_d;
      na_q      <= na_d;
      b_q       <= b_d;
      nb_q      <= nb_d;
      mostrar_q <= mostrar_de(estado_d);
    end
  end

  assign bus.dig1_1       = a_q[0];
  assign bus.dig1_2       = a_q[1];
  assign bus.dig1_3       = a_q[2];
  assign bus.dig2_1       = b_q[0];
  assign bus.dig2_2       = b_q[1];
  assign bus.dig2_3       = b_q[2];
  assign bus.mostrar      = mostrar_q;
  assign bus.tecla_valida = valida_s;
  assign bus.tecla_codigo = codigo_s;

endmodule

// File: tb/tb_control_entrada_suma.sv
// Directed and randomized keypad sessions checked against a decimal-value reference model.
module tb_control_entrada_suma;

  localparam int ST = 4;
  localparam int DB = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  columnas;
  logic [3:0]  filas;
  logic [15:0] pulsadas = 16'h0000;

  control_entrada_suma_if bus ();

  control_entrada_suma #(
    .SCAN_TICKS     (ST),
    .DEBOUNCE_TICKS (DB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .columnas (columnas),
    .filas    (filas),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Keypad: a held key at (r,c) pulls column c low while row r is driven low.
  always_comb begin
    columnas = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pulsadas[r*4+c] && (filas[r] == 1'b0)) columnas[c] = 1'b0;
  end

  int pulsos = 0;
  always @(posedge clk) if (bus.tecla_valida === 1'b1) pulsos <= pulsos + 1;

  logic [3:0] kmap [0:15] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};

  int compared = 0;
  int mismatched = 0;

  int mod_a, mod_na, mod_b, mod_nb, fase, exp_pulsos;
  logic [3:0] exp_codigo;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelo_reset();
    mod_a = 0; mod_na = 0; mod_b = 0; mod_nb = 0; fase = 0;
    exp_codigo = 4'h0;
  endtask

  task automatic modelo_tecla(input logic [3:0] k);
    exp_pulsos++;
    exp_codigo = k;
    if (k == 4'hC) begin
      mod_a = 0; mod_na = 0; mod_b = 0; mod_nb = 0; fase = 0;
    end else if (k <= 4'd9) begin
      if (fase == 0 && mod_na < 3) begin
        mod_a = mod_a * 10 + int'(k); mod_na++;
      end else if (fase == 1 && mod_nb < 3) begin
        mod_b = mod_b * 10 + int'(k); mod_nb++;
      end else if (fase == 2) begin
        mod_a = int'(k); mod_na = 1; mod_b = 0; mod_nb = 0; fase = 0;
      end
    end else if (k == 4'hA && fase == 0) begin
      fase = 1; mod_b = 0; mod_nb = 0;
    end else if (k == 4'hB && fase == 1) begin
      fase = 2;
    end
  endtask

  task automatic check_salidas(input string tag);
    check({tag, " dig1_1"}, 32'(bus.dig1_1), mod_a % 10);
    check({tag, " dig1_2"}, 32'(bus.dig1_2), (mod_a / 10) % 10);
    check({tag, " dig1_3"}, 32'(bus.dig1_3), mod_a / 100);
    check({tag, " dig2_1"}, 32'(bus.dig2_1), mod_b % 10);
    check({tag, " dig2_2"}, 32'(bus.dig2_2), (mod_b / 10) % 10);
    check({tag, " dig2_3"}, 32'(bus.dig2_3), mod_b / 100);
    check({tag, " mostrar"}, 32'(bus.mostrar), fase);
    check({tag, " codigo"}, 32'(bus.tecla_codigo), 32'(exp_codigo));
    check({tag, " pulsos"}, pulsos, exp_pulsos);
  endtask

  function automatic int pos_tecla(input logic [3:0] k);
    for (int i = 0; i < 16; i++) if (kmap[i] == k) return i;
    return 0;
  endfunction

  task automatic pulsar(input logic [3:0] k, input int hold);
    int idx, n, p0;
    idx = pos_tecla(k);
    p0 = pulsos;
    n = 0;
    pulsadas[idx] = 1'b1;
    while (pulsos == p0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (hold) @(negedge clk);
    pulsadas[idx] = 1'b0;
    repeat (DB + 12) @(negedge clk);
    modelo_tecla(k);
    check_salidas($sformatf("tecla %0h", k));
  endtask

  task automatic esperar_fila(input int r);
    logic [3:0] objetivo;
    int n;
    objetivo = ~(4'b0001 << r);
    n = 0;
    while (filas === objetivo && n < 100) begin @(negedge clk); n++; end
    while (filas !== objetivo && n < 100) begin @(negedge clk); n++; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    logic [3:0] ign [0:2];
    ign[0] = 4'hD; ign[1] = 4'hE; ign[2] = 4'hF;
    modelo_reset();
    exp_pulsos = 0;

    // 1: reset mid-scan and row rotation
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset filas", 32'(filas), 32'(4'b1110));
    check_salidas("reset");
    check("reset valida", 32'(bus.tecla_valida), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("fila0 sostenida", 32'(filas), 32'(4'b1110));
    @(negedge clk);
    check("fila1", 32'(filas), 32'(4'b1101));
    repeat (4) @(negedge clk);
    check("fila2", 32'(filas), 32'(4'b1011));
    repeat (4) @(negedge clk);
    check("fila3", 32'(filas), 32'(4'b0111));
    repeat (4) @(negedge clk);
    check("fila0 vuelta", 32'(filas), 32'(4'b1110));

    // 2: basic sum entry
    pulsar(4'h1, 2); pulsar(4'h2, 2); pulsar(4'h3, 2); pulsar(4'hA, 2);
    pulsar(4'h4, 2); pulsar(4'h5, 2); pulsar(4'hB, 2);
    check("siete pulsos", pulsos, 7);

    // 3: saturating digit count
    pulsar(4'hC, 2);
    pulsar(4'h9, 2); pulsar(4'h8, 2); pulsar(4'h7, 2); pulsar(4'h6, 2);

    // 4: bounce then long hold
    esperar_fila(1);
    pulsadas[5] = 1'b1; repeat (5) @(negedge clk);
    pulsadas[5] = 1'b0; repeat (1) @(negedge clk);
    pulsadas[5] = 1'b1; repeat (20) @(negedge clk);
    pulsadas[5] = 1'b0; repeat (20) @(negedge clk);
    modelo_tecla(4'h5);
    check_salidas("rebote");
    pulsar(4'h5, 100);

    // 5: chord in one row, then a second key while the first is held
    pulsar(4'hC, 2);
    pulsadas[0] = 1'b1; pulsadas[1] = 1'b1;
    repeat (60) @(negedge clk);
    pulsadas[0] = 1'b0; pulsadas[1] = 1'b0;
    repeat (25) @(negedge clk);
    check("acorde sin pulso", pulsos, exp_pulsos);
    pulsadas[4] = 1'b1;
    nd = 0;
    while (pulsos == exp_pulsos && nd < 200) begin @(negedge clk); nd++; end
    pulsadas[6] = 1'b1; pulsadas[8] = 1'b1;
    repeat (40) @(negedge clk);
    pulsadas[4] = 1'b0;
    repeat (40) @(negedge clk);
    pulsadas[6] = 1'b0; pulsadas[8] = 1'b0;
    repeat (25) @(negedge clk);
    modelo_tecla(4'h4);
    check_salidas("segunda tecla");

    // 6: digit in RESULTADO, clear in ENTRADA_B, reset during debounce
    pulsar(4'hA, 2); pulsar(4'h2, 2); pulsar(4'hB, 2);
    pulsar(4'h7, 2);
    pulsar(4'hA, 2); pulsar(4'h3, 2); pulsar(4'hC, 2);
    pulsar(4'h5, 2);
    esperar_fila(0);
    pulsadas[1] = 1'b1;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    pulsadas = 16'h0000;
    modelo_reset();
    repeat (3) @(negedge clk);
    check("reset rebote filas", 32'(filas), 32'(4'b1110));
    check_salidas("reset rebote");
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check_salidas("tras reset");

    // randomized sessions, including ignored keys
    for (int s = 0; s < 4; s++) begin
      pulsar(4'hC, $urandom_range(0, 5));
      nd = $urandom_range(1, 4);
      for (int i = 0; i < nd; i++) pulsar(4'($urandom_range(0, 9)), $urandom_range(0, 5));
      pulsar(ign[$urandom_range(0, 2)], 1);
      pulsar(4'hB, 1);
      pulsar(4'hA, 1);
      nd = $urandom_range(1, 4);
      for (int i = 0; i < nd; i++) pulsar(4'($urandom_range(0, 9)), $urandom_range(0, 5));
      pulsar(4'hA, 1);
      pulsar(4'hB, 1);
      if ($urandom_range(0, 1) == 1) pulsar(4'($urandom_range(0, 9)), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
